// File: rtl/irda_fir_pkg.sv
// Shared definitions for the IrDA FIR receive framer: state encoding, CRC-32
// constants and the serial CRC step.
package irda_fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PA    = 3'd1,
    ST_SKIP  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE_DEF = 32'hC704_DD7B;
  localparam int          STA_SKIP_DEF    = 18;

  // Shift-left form fed LSB-first: the register holds the bit-reverse of the
  // usual reflected CRC, which is why the good-frame residue reads C704DD7B.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    return {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/irda_crc32_ser.sv
// Bit-serial CRC-32 accumulator; clr preloads the init value, en absorbs one bit.
module irda_crc32_ser
  import irda_fir_pkg::*;
(
  input  logic        clk,
  input  logic        wb_rst_n_i,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [31:0] crc_o
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      crc_o <= '0;
    end else if (clr) begin
      crc_o <= CRC_INIT;
    end else if (en) begin
      crc_o <= crc32_step(crc_o, din);
    end
  end

endmodule

// File: rtl/irda_fir_rx_framer.sv
// IrDA FIR receive framer: tracks preamble/start/stop flags, packs decoded bits
// into words on a valid/ready port and reports CRC, length, overrun and abort.
module irda_fir_rx_framer
  import irda_fir_pkg::*;
#(
  parameter int          WORD_W      = 32,
  parameter int          LEN_W       = 19,
  parameter int          STA_SKIP    = STA_SKIP_DEF,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEF
) (
  input  logic                        clk,
  input  logic                        wb_rst_n_i,
  input  logic                        rx_en,
  input  logic                        rx_restart,
  input  logic                        pa_det,
  input  logic                        sta_det,
  input  logic                        sto_det,
  input  logic                        rx_bit,
  input  logic                        rx_abort,
  output logic [WORD_W-1:0]           word_o,
  output logic                        word_valid_o,
  input  logic                        word_ready_i,
  output logic                        word_last_o,
  output logic [$clog2(WORD_W/8):0]   word_nbytes_o,
  output logic                        frame_done_o,
  output logic                        crc_err_o,
  output logic                        len_err_o,
  output logic                        ovr_err_o,
  output logic                        abort_o,
  output logic [LEN_W-4:0]            byte_cnt_o
);

  localparam int AW     = $clog2(WORD_W);
  localparam int NB_W   = $clog2(WORD_W / 8) + 1;
  localparam int SKIP_W = (STA_SKIP < 1) ? 1 : $clog2(STA_SKIP + 1);

  state_t              state;
  logic [LEN_W-1:0]    bitcount;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [WORD_W-1:0]   asm_q;
  logic [WORD_W-1:0]   asm_set;
  logic [AW-1:0]       pos;
  logic                bit_sat;
  logic                word_full;
  logic                data_tick;
  logic                emit_now;
  logic [WORD_W-1:0]   emit_word;
  logic [NB_W-1:0]     emit_nb;
  logic                emit_last;
  logic                can_load;
  logic                crc_clr;
  logic                crc_en;
  logic [31:0]         crc;

  assign pos        = bitcount[AW-1:0];
  assign bit_sat    = &bitcount;
  assign word_full  = &pos;
  assign can_load   = !word_valid_o || word_ready_i;
  assign byte_cnt_o = bitcount[LEN_W-1:3];

  // A bit is absorbed only on a clean DATA tick; the stop-flag tick carries no data.
  assign data_tick = rx_en && !rx_restart && !rx_abort && (state == ST_DATA)
                     && !sto_det && !bit_sat;
  assign crc_en    = data_tick;
  assign crc_clr   = rx_en && !rx_restart && (state == ST_IDLE) && pa_det;

  irda_crc32_ser u_crc (
    .clk        (clk),
    .wb_rst_n_i (wb_rst_n_i),
    .clr        (crc_clr),
    .en         (crc_en),
    .din        (rx_bit),
    .crc_o      (crc)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    asm_set      = asm_q;
    asm_set[pos] = rx_bit;
    emit_now     = 1'b0;
    emit_word    = asm_set;
    emit_nb      = NB_W'(WORD_W / 8);
    emit_last    = 1'b0;
    if (data_tick && word_full) begin
      emit_now = 1'b1;
    end else if (rx_en && !rx_restart && !rx_abort && state == ST_CHECK) begin
      emit_now  = 1'b1;
      emit_word = asm_q;
      emit_nb   = NB_W'(pos >> 3);
      emit_last = 1'b1;
    end
  end

  // NOTE: the assembly register is reset like any other flop; it is a single
  // word, not a storage array, so reset costs nothing and keeps word_o clean.
  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= ST_IDLE;
      bitcount      <= '0;
      skip_cnt      <= '0;
      asm_q         <= '0;
      word_o        <= '0;
      word_valid_o  <= 1'b0;
      word_last_o   <= 1'b0;
      word_nbytes_o <= '0;
      frame_done_o  <= 1'b0;
      crc_err_o     <= 1'b0;
      len_err_o     <= 1'b0;
      ovr_err_o     <= 1'b0;
      abort_o       <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (word_valid_o && word_ready_i) begin
        word_valid_o <= 1'b0;
      end

      // A fresh word overrides the handshake drop above; a busy port drops it.
      if (emit_now) begin
        if (can_load) begin
          word_o        <= emit_word;
          word_nbytes_o <= emit_nb;
          word_last_o   <= emit_last;
          word_valid_o  <= 1'b1;
        end else begin
          ovr_err_o <= 1'b1;
        end
      end

      if (rx_restart) begin
        state        <= ST_IDLE;
        asm_q        <= '0;
        word_valid_o <= 1'b0;
        bitcount     <= '0;
        skip_cnt     <= '0;
        crc_err_o    <= 1'b0;
        len_err_o    <= 1'b0;
        ovr_err_o    <= 1'b0;
        abort_o      <= 1'b0;
      end else if (rx_en) begin
        if (state != ST_IDLE && rx_abort) begin
          state   <= ST_IDLE;
          abort_o <= 1'b1;
          asm_q   <= '0;
        end else begin
          unique case (state)
            ST_IDLE: begin
              if (pa_det) begin
                state     <= ST_PA;
                bitcount  <= '0;
                asm_q     <= '0;
                crc_err_o <= 1'b0;
                len_err_o <= 1'b0;
                ovr_err_o <= 1'b0;
                abort_o   <= 1'b0;
              end
            end
            ST_PA: begin
              if (sta_det) begin
                state    <= ST_SKIP;
                skip_cnt <= SKIP_W'(STA_SKIP);
              end
            end
            ST_SKIP: begin
              if (skip_cnt == '0) state <= ST_DATA;
              else                skip_cnt <= skip_cnt - 1'b1;
            end
            ST_DATA: begin
              if (sto_det) begin
                state <= ST_CHECK;
              end else if (!bit_sat) begin
                bitcount <= bitcount + 1'b1;
                asm_q    <= word_full ? '0 : asm_set;
              end
            end
            ST_CHECK: begin
              if (crc != CRC_RESIDUE) crc_err_o <= 1'b1;
              if ((bitcount[2:0] != 3'd0) || (bitcount < LEN_W'(32)) || bit_sat) begin
                len_err_o <= 1'b1;
              end
              asm_q        <= '0;
              frame_done_o <= 1'b1;
              state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_irda_fir_rx_framer.sv
// Directed bench for irda_fir_rx_framer: a 32-bit instance and an 8-bit
// instance share the same receive stimulus.
module tb_irda_fir_rx_framer;
  import irda_fir_pkg::*;

  localparam int SKIP_TICKS = 19;  // STA_SKIP=18 -> 18..0 inclusive

  logic clk = 1'b0, wb_rst_n_i = 1'b0, rx_en = 1'b0, rx_restart = 1'b0;
  logic pa_det = 1'b0, sta_det = 1'b0, sto_det = 1'b0, rx_bit = 1'b0, rx_abort = 1'b0;
  logic word_ready_i = 1'b0;

  logic [31:0] word_o;
  logic        word_valid_o, word_last_o, frame_done_o;
  logic [2:0]  word_nbytes_o;
  logic        crc_err_o, len_err_o, ovr_err_o, abort_o;
  logic [15:0] byte_cnt_o;

  logic [7:0]  w8_word;
  logic        w8_valid, w8_last, w8_done, w8_crc, w8_len, w8_ovr, w8_abort;
  logic [0:0]  w8_nb;
  logic [15:0] w8_bytes;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] q_word[$];
  logic [2:0]  q_nb[$];
  logic        q_last[$];
  logic [7:0]  q8_word[$];
  logic        q8_nb[$];
  logic        q8_last[$];

  logic        tx_bits[$];
  logic [31:0] exp_fcs;

  irda_fir_rx_framer dut (
    .clk(clk), .wb_rst_n_i(wb_rst_n_i), .rx_en(rx_en), .rx_restart(rx_restart),
    .pa_det(pa_det), .sta_det(sta_det), .sto_det(sto_det), .rx_bit(rx_bit),
    .rx_abort(rx_abort), .word_o(word_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .word_last_o(word_last_o),
    .word_nbytes_o(word_nbytes_o), .frame_done_o(frame_done_o),
    .crc_err_o(crc_err_o), .len_err_o(len_err_o), .ovr_err_o(ovr_err_o),
    .abort_o(abort_o), .byte_cnt_o(byte_cnt_o)
  );

  irda_fir_rx_framer #(.WORD_W(8)) dut8 (
    .clk(clk), .wb_rst_n_i(wb_rst_n_i), .rx_en(rx_en), .rx_restart(rx_restart),
    .pa_det(pa_det), .sta_det(sta_det), .sto_det(sto_det), .rx_bit(rx_bit),
    .rx_abort(rx_abort), .word_o(w8_word), .word_valid_o(w8_valid),
    .word_ready_i(word_ready_i), .word_last_o(w8_last),
    .word_nbytes_o(w8_nb), .frame_done_o(w8_done),
    .crc_err_o(w8_crc), .len_err_o(w8_len), .ovr_err_o(w8_ovr),
    .abort_o(w8_abort), .byte_cnt_o(w8_bytes)
  );

  always #5 clk = ~clk;

  // Handshakes complete on the following rising edge; inputs only change 1 ns after it.
  always @(negedge clk) begin
    if (word_valid_o && word_ready_i) begin
      q_word.push_back(word_o);
      q_nb.push_back(word_nbytes_o);
      q_last.push_back(word_last_o);
    end
    if (w8_valid && word_ready_i) begin
      q8_word.push_back(w8_word);
      q8_nb.push_back(w8_nb[0]);
      q8_last.push_back(w8_last);
    end
    if (frame_done_o) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRC-32 in the conventional reflected (shift-right) form.
  function automatic logic [31:0] fcs_of(input logic [31:0] data);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else                c = c >> 1;
    end
    return ~c;
  endfunction

  task automatic build_bits(input int flip, input int extra);
    logic [31:0] data;
    data    = 32'h0403_0201;
    exp_fcs = fcs_of(data);
    tx_bits.delete();
    for (int i = 0; i < 32; i++) tx_bits.push_back((i == flip) ? ~data[i] : data[i]);
    for (int i = 0; i < 32; i++) tx_bits.push_back(exp_fcs[i]);
    for (int i = 0; i < extra; i++) tx_bits.push_back(1'b1);
  endtask

  task automatic clear_obs();
    q_word.delete(); q_nb.delete(); q_last.delete();
    q8_word.delete(); q8_nb.delete(); q8_last.delete();
    done_cnt = 0;
  endtask

  task automatic drive(input logic en, input logic pa, input logic sta, input logic sto,
                       input logic b, input logic ab, input logic rs);
    @(posedge clk);
    #1;
    rx_en = en; pa_det = pa; sta_det = sta; sto_det = sto;
    rx_bit = b; rx_abort = ab; rx_restart = rs;
  endtask

  task automatic run_frame(input int abort_at, input int stop_at);
    bit aborted;
    aborted = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    repeat (SKIP_TICKS) drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(tx_bits.size()); i++) begin
      if (i == stop_at) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (i == abort_at) begin
        drive(1, 0, 0, 0, tx_bits[i], 1, 0);
        aborted = 1'b1;
        break;
      end
      drive(1, 0, 0, 0, tx_bits[i], 0, 0);
    end
    if (!aborted) begin
      drive(1, 0, 0, 1, 1, 0, 0);  // stop-flag tick with a stray 1 that must be ignored
      drive(1, 0, 0, 0, 0, 0, 0);
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    wb_rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({word_o, word_valid_o, word_last_o, word_nbytes_o, frame_done_o, crc_err_o,
         len_err_o, ovr_err_o, abort_o, byte_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got word=%h valid=%b nb=%0d bytes=%0d exp all zero",
               word_o, word_valid_o, word_nbytes_o, byte_cnt_o);
    end
    wb_rst_n_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({word_valid_o, frame_done_o, crc_err_o, len_err_o, ovr_err_o, abort_o} !== 6'b0
        || dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release got valid=%b done=%b state=%0d exp quiet IDLE",
               word_valid_o, frame_done_o, dut.state);
    end
  endtask

  task automatic test_good_frame();
    logic [31:0] ew[3];
    logic [2:0]  en[3];
    logic [63:0] stream;
    word_ready_i = 1'b1;
    clear_obs();
    build_bits(-1, 0);
    run_frame(-1, -1);
    ew = '{32'h0403_0201, exp_fcs, 32'h0};
    en = '{3'd4, 3'd4, 3'd0};
    checks++;
    if (q_word.size() !== 3) begin
      errors++;
      $display("FAIL good_word_count got %0d exp 3", q_word.size());
    end
    for (int i = 0; i < 3 && i < int'(q_word.size()); i++) begin
      checks++;
      if ({q_word[i], q_nb[i], q_last[i]} !== {ew[i], en[i], (i == 2)}) begin
        errors++;
        $display("FAIL good_word%0d got %h/nb%0d/last%b exp %h/nb%0d/last%b",
                 i, q_word[i], q_nb[i], q_last[i], ew[i], en[i], (i == 2));
      end
    end
    checks++;
    if ({crc_err_o, len_err_o, ovr_err_o, abort_o} !== 4'b0 || byte_cnt_o !== 16'd8
        || done_cnt !== 1) begin
      errors++;
      $display("FAIL good_status got crc=%b len=%b ovr=%b abort=%b bytes=%0d done=%0d exp 0 0 0 0 8 1",
               crc_err_o, len_err_o, ovr_err_o, abort_o, byte_cnt_o, done_cnt);
    end
    stream = {exp_fcs, 32'h0403_0201};
    checks++;
    if (q8_word.size() !== 9) begin
      errors++;
      $display("FAIL w8_word_count got %0d exp 9", q8_word.size());
    end
    for (int i = 0; i < 9 && i < int'(q8_word.size()); i++) begin
      checks++;
      if ({q8_word[i], q8_nb[i], q8_last[i]} !==
          {((i < 8) ? stream[8*i +: 8] : 8'h00), (i < 8), (i == 8)}) begin
        errors++;
        $display("FAIL w8_word%0d got %h/nb%0d/last%b", i, q8_word[i], q8_nb[i], q8_last[i]);
      end
    end
  endtask

  task automatic test_crc_error();
    logic [31:0] ew[3];
    clear_obs();
    build_bits(5, 0);
    run_frame(-1, -1);
    ew = '{32'h0403_0221, exp_fcs, 32'h0};
    checks++;
    if (q_word.size() !== 3 || crc_err_o !== 1'b1 || len_err_o !== 1'b0) begin
      errors++;
      $display("FAIL crc_flag got words=%0d crc=%b len=%b exp 3 1 0",
               q_word.size(), crc_err_o, len_err_o);
    end
    for (int i = 0; i < 3 && i < int'(q_word.size()); i++) begin
      checks++;
      if (q_word[i] !== ew[i]) begin
        errors++;
        $display("FAIL crc_word%0d got %h exp %h", i, q_word[i], ew[i]);
      end
    end
  endtask

  task automatic test_length_error();
    clear_obs();
    build_bits(-1, 4);
    run_frame(-1, -1);
    checks++;
    if (len_err_o !== 1'b1 || byte_cnt_o !== 16'd8 || q_word.size() !== 3) begin
      errors++;
      $display("FAIL len_flag got len=%b bytes=%0d words=%0d exp 1 8 3",
               len_err_o, byte_cnt_o, q_word.size());
    end
    if (q_word.size() == 3) begin
      checks++;
      if ({q_word[2], q_nb[2], q_last[2]} !== {32'h0000_000F, 3'd0, 1'b1}) begin
        errors++;
        $display("FAIL len_last got %h/nb%0d/last%b exp 0000000f/nb0/last1",
                 q_word[2], q_nb[2], q_last[2]);
      end
    end
  endtask

  task automatic test_overflow();
    word_ready_i = 1'b0;
    clear_obs();
    build_bits(-1, 0);
    run_frame(-1, -1);
    checks++;
    if ({word_o, word_nbytes_o, word_last_o, word_valid_o, ovr_err_o}
        !== {32'h0403_0201, 3'd4, 1'b0, 1'b1, 1'b1} || done_cnt !== 1) begin
      errors++;
      $display("FAIL ovr_hold got word=%h nb=%0d last=%b valid=%b ovr=%b done=%0d exp 04030201 4 0 1 1 1",
               word_o, word_nbytes_o, word_last_o, word_valid_o, ovr_err_o, done_cnt);
    end
    word_ready_i = 1'b1;
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_word.size() !== 1 || word_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drain got words=%0d valid=%b exp 1 0", q_word.size(), word_valid_o);
    end else if (q_word[0] !== 32'h0403_0201) begin
      errors++;
      $display("FAIL ovr_drain_word got %h exp 04030201", q_word[0]);
    end
  endtask

  task automatic test_abort();
    word_ready_i = 1'b1;
    clear_obs();
    build_bits(-1, 0);
    run_frame(20, -1);
    checks++;
    if (abort_o !== 1'b1 || done_cnt !== 0 || q_word.size() !== 0 || dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL abort got abort=%b done=%0d words=%0d state=%0d exp 1 0 0 IDLE",
               abort_o, done_cnt, q_word.size(), dut.state);
    end
    clear_obs();
    run_frame(-1, -1);
    checks++;
    if (abort_o !== 1'b0 || crc_err_o !== 1'b0 || done_cnt !== 1 || q_word.size() !== 3) begin
      errors++;
      $display("FAIL abort_recover got abort=%b crc=%b done=%0d words=%0d exp 0 0 1 3",
               abort_o, crc_err_o, done_cnt, q_word.size());
    end else if (q_word[0] !== 32'h0403_0201 || q_word[1] !== exp_fcs) begin
      errors++;
      $display("FAIL abort_recover_words got %h %h exp 04030201 %h", q_word[0], q_word[1], exp_fcs);
    end
  endtask

  task automatic test_restart();
    word_ready_i = 1'b0;
    clear_obs();
    build_bits(-1, 0);
    run_frame(-1, 40);
    checks++;
    if (word_valid_o !== 1'b1 || byte_cnt_o !== 16'd5) begin
      errors++;
      $display("FAIL restart_pre got valid=%b bytes=%0d exp 1 5", word_valid_o, byte_cnt_o);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (word_valid_o !== 1'b0 || byte_cnt_o !== 16'd0 || dut.state !== ST_IDLE
        || {crc_err_o, len_err_o, ovr_err_o, abort_o} !== 4'b0) begin
      errors++;
      $display("FAIL restart got valid=%b bytes=%0d state=%0d exp 0 0 IDLE",
               word_valid_o, byte_cnt_o, dut.state);
    end
    word_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid_data();
    word_ready_i = 1'b0;
    build_bits(-1, 0);
    run_frame(-1, 40);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    checks++;
    if ({word_o, word_valid_o, word_last_o, word_nbytes_o, frame_done_o, crc_err_o,
         len_err_o, ovr_err_o, abort_o, byte_cnt_o} !== '0 || dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid got word=%h valid=%b bytes=%0d state=%0d exp zero IDLE",
               word_o, word_valid_o, byte_cnt_o, dut.state);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    wb_rst_n_i   = 1'b1;
    word_ready_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length_error();
    test_overflow();
    test_abort();
    test_restart();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
